// File: rtl/mat_operand_driver.sv
// Operand stimulus source: streams one DIM x DIM matrix of pattern-generated signed
// elements, row-major, over valid/ready. Define MAT_DRV_TIMEOUT_EN to build the stall watchdog.
module mat_operand_driver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIM         = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic signed [DATA_W-1:0]  seed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic [$clog2(DIM)-1:0]    out_row,
  output logic [$clog2(DIM)-1:0]    out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err
);

  localparam int unsigned ROW_W = $clog2(DIM);
  localparam int unsigned K_W   = $clog2(DIM * DIM);
  localparam logic [ROW_W-1:0] IDX_MAX = ROW_W'(DIM - 1);

  typedef enum logic {IDLE, DRIVE} state_e;

  state_e                     state_q, state_d;
  logic                       valid_q, valid_d;
  logic signed [DATA_W-1:0]   data_q, data_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [ROW_W-1:0]           col_q, col_d;
  logic                       last_q, last_d;
  logic [1:0]                 mode_q, mode_d;
  logic signed [DATA_W-1:0]   seed_q, seed_d;
  logic                       done_q, done_d;
  logic                       terr_q, terr_d;
  logic                       wd_fire;
  logic [ROW_W-1:0]           nrow, ncol;

  // Element value for coordinate (r, c); all arithmetic wraps modulo 2^DATA_W.
  function automatic logic signed [DATA_W-1:0] pattern(
    input logic [1:0]               m,
    input logic signed [DATA_W-1:0] s,
    input logic [ROW_W-1:0]         r,
    input logic [ROW_W-1:0]         c
  );
    logic [K_W-1:0] k;
    k = K_W'(r) * K_W'(DIM) + K_W'(c);
    case (m)
      2'd0:    pattern = s + DATA_W'(k);
      2'd1:    pattern = k[0] ? -s : s;
      2'd2:    pattern = s;
      default: pattern = (r == c) ? s : '0;
    endcase
  endfunction

`ifdef MAT_DRV_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;

  // Counts consecutive stalled cycles; any non-stalled cycle clears it.
  always_comb begin
    stall_d = '0;
    if (state_q == DRIVE && valid_q && !out_ready) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign wd_fire = (state_q == DRIVE) && valid_q && !out_ready &&
                   (stall_q == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign ncol = (col_q == IDX_MAX) ? '0 : col_q + ROW_W'(1);
  assign nrow = (col_q == IDX_MAX) ? row_q + ROW_W'(1) : row_q;

  // Next-state and registered-output logic; abort beats watchdog beats handshake.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    last_d  = last_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          mode_d  = mode;
          seed_d  = seed;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          terr_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (wd_fire) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          terr_d  = 1'b1;
        end else if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            row_d  = nrow;
            col_d  = ncol;
            data_d = pattern(mode_q, seed_q, nrow, ncol);
            last_d = (nrow == IDX_MAX) && (ncol == IDX_MAX);
          end
        end else if (!valid_q) begin
          // First DRIVE cycle: present element (0,0) from the latched mode/seed.
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          data_d  = pattern(mode_q, seed_q, '0, '0);
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      mode_q  <= '0;
      seed_q  <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_last    = last_q;
  assign busy        = (state_q == DRIVE);
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mat_operand_driver.sv
// Directed bench for mat_operand_driver (DIM=4, DATA_W=8, TIMEOUT_CYC=16).
module tb_mat_operand_driver;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic signed [7:0] seed;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int q_data[$];
  int q_row[$];
  int q_col[$];
  int q_last[$];
  int done_seen;
  int stream_cyc;

  mat_operand_driver #(.DATA_W(8), .DIM(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference element value for beat i of a 4x4 run.
  function automatic int exp_pat(input int m, input int s, input int i);
    logic signed [7:0] v;
    logic signed [7:0] sv;
    sv = 8'(s);
    case (m)
      0:       v = 8'(s + i);
      1:       v = (i % 2 == 1) ? -sv : sv;
      2:       v = sv;
      default: v = ((i / 4) == (i % 4)) ? sv : 8'sd0;
    endcase
    return int'(v);
  endfunction

  task automatic start_run(input int m, input int s);
    mode  = 2'(m);
    seed  = 8'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_valid_lag", int'(out_valid), 0);
  endtask

  // Runs the stream to completion; style 0 = always ready, 1 = ready every other cycle.
  task automatic stream(input int style, input int budget);
    logic stalled;
    int pd, pr, pc, pl;
    q_data.delete(); q_row.delete(); q_col.delete(); q_last.delete();
    done_seen  = 0;
    stream_cyc = 0;
    while (stream_cyc < budget) begin
      out_ready = (style == 0) ? 1'b1 : (stream_cyc % 2 == 0);
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_row.push_back(int'(out_row));
        q_col.push_back(int'(out_col));
        q_last.push_back(int'(out_last));
      end
      stalled = out_valid && !out_ready;
      pd = int'(out_data); pr = int'(out_row); pc = int'(out_col); pl = int'(out_last);
      tick();
      stream_cyc++;
      if (stalled && out_valid) begin
        check("hold_data", int'(out_data), pd);
        check("hold_row", int'(out_row), pr);
        check("hold_col", int'(out_col), pc);
        check("hold_last", int'(out_last), pl);
      end
      if (done) begin
        done_seen++;
        check("done_busy_low", int'(busy), 0);
      end
      if (!busy) break;
    end
    if (busy) check("stream_budget", 1, 0);
    out_ready = 1'b1;
  endtask

  task automatic check_run(input string tag, input int m, input int s);
    check({tag, "_beats"}, q_data.size(), 16);
    check({tag, "_done"}, done_seen, 1);
    for (int i = 0; i < q_data.size(); i++) begin
      check({tag, "_data"}, q_data[i], exp_pat(m, s, i));
      check({tag, "_row"}, q_row[i], i / 4);
      check({tag, "_col"}, q_col[i], i % 4);
      check({tag, "_last"}, q_last[i], (i == 15) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_row"}, int'(out_row), 0);
    check({tag, "_col"}, int'(out_col), 0);
    check({tag, "_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_terr"}, int'(timeout_err), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; seed = 8'sd0; out_ready = 1'b1;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ramp from seed 5: values 5..20, one beat per cycle.
    start_run(0, 5);
    stream(0, 60);
    check_run("ramp5", 0, 5);
    check("ramp5_first", q_data[0], 5);
    check("ramp5_lastval", q_data[15], 20);
    check("ramp5_cycles", stream_cyc, 17);

    // Restart in the done cycle: ramp wrap 127 -> -128.
    start_run(0, 120);
    stream(0, 60);
    check_run("ramp120", 0, 120);
    check("wrap_beat8", q_data[7], 127);
    check("wrap_beat9", q_data[8], -128);

    start_run(1, -128);
    stream(0, 60);
    check_run("alt_neg128", 1, -128);

    start_run(1, 3);
    stream(0, 60);
    check_run("alt3", 1, 3);

    start_run(2, -3);
    stream(0, 60);
    check_run("const", 2, -3);

    // Backpressure on scaled identity.
    start_run(3, 7);
    stream(1, 100);
    check_run("ident", 3, 7);
    check("ident_diag", q_data[5], 7);
    check("ident_offdiag", q_data[4], 0);

    // Stall: two transfers, then out_ready held low.
    start_run(0, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("stall_col", int'(out_col), 2);
    repeat (15) tick();
    check("stall15_terr", int'(timeout_err), 0);
    check("stall15_valid", int'(out_valid), 1);
    check("stall15_col", int'(out_col), 2);
`ifdef MAT_DRV_TIMEOUT_EN
    tick();
    check("wd_terr", int'(timeout_err), 1);
    check("wd_valid", int'(out_valid), 0);
    check("wd_busy", int'(busy), 0);
    check("wd_done", int'(done), 0);
    tick();
    check("wd_terr_sticky", int'(timeout_err), 1);
    start_run(1, 3);
    check("wd_terr_cleared", int'(timeout_err), 0);
    stream(0, 60);
    check_run("after_wd", 1, 3);
`else
    repeat (25) tick();
    check("nowd_terr", int'(timeout_err), 0);
    check("nowd_valid", int'(out_valid), 1);
    check("nowd_data", int'(out_data), 2);
    stream(0, 60);
    check("nowd_beats", q_data.size(), 14);
    check("nowd_first", q_data[0], 2);
    check("nowd_done", done_seen, 1);
`endif

    // Abort on the last handshake; a start while busy is ignored.
    start_run(2, 9);
    out_ready = 1'b1;
    repeat (3) tick();
    mode = 2'd0; seed = 8'sd99; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_data", int'(out_data), 9);
    check("busy_start_busy", int'(busy), 1);
    for (int n = 0; n < 40 && !out_last; n++) tick();
    check("abort_at_last", int'(out_last), 1);
    check("abort_last_row", int'(out_row), 3);
    check("abort_last_col", int'(out_col), 3);
    check("abort_last_data", int'(out_data), 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    tick();
    check("abort_done_later", int'(done), 0);

    // Mid-run reset at beat 6, then a fresh run restarts at (0,0).
    start_run(0, 10);
    out_ready = 1'b1;
    repeat (6) tick();
    check("pre_rst_data", int'(out_data), 15);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    start_run(0, 40);
    tick();
    check("restart_row", int'(out_row), 0);
    check("restart_col", int'(out_col), 0);
    check("restart_data", int'(out_data), 40);
    stream(0, 60);
    check("restart_done", done_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
